// File: rtl/jzjpcc_mem_load_returner.sv
// jzjpcc_mem_load_returner
// Memory-stage load return path. A load captured in IDLE waits in WAIT for
// the data bus, then the addressed byte/halfword/word is extended and
// handed to writeback as a registered one-cycle pulse. A watchdog aborts
// loads whose response never arrives.
//
// Optional feature macro: JZJPCC_LOAD_MISALIGN_CHECK_EN
//   defined   -> misaligned LH/LHU/LW are rejected in IDLE and reported on
//                loadMisaligned instead of being issued.
//   undefined -> loadMisaligned stays 0 and every load is issued.
module jzjpcc_mem_load_returner #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadStart_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [1:0]  byteOffset_execute,
  input  logic [4:0]  rdAddress_execute,
  input  logic        memReadValid,
  input  logic [31:0] memReadData,
  output logic [31:0] loadResult_writeback,
  output logic        loadResultValid_writeback,
  output logic [4:0]  rdAddress_writeback,
  output logic        loadBusy,
  output logic        loadTimeout,
  output logic        loadMisaligned
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Counter value on which a still-unanswered WAIT cycle gives up.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_count;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic        r_valid;
  logic [4:0]  r_rd_wb;
  logic        r_timeout;
  logic        r_misaligned;
  logic        w_misaligned;

  // Select and extend the loaded field from the returned word.
  function automatic logic [31:0] extract_load(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_res;
    case (off)
      2'd0:    v_byte = word[7:0];
      2'd1:    v_byte = word[15:8];
      2'd2:    v_byte = word[23:16];
      2'd3:    v_byte = word[31:24];
      default: v_byte = word[7:0];
    endcase
    // Bit 0 of the offset is deliberately ignored for halfwords.
    v_half = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  v_res = {{24{v_byte[7]}}, v_byte};
      3'b001:  v_res = {{16{v_half[15]}}, v_half};
      3'b010:  v_res = word;
      3'b100:  v_res = {24'h000000, v_byte};
      3'b101:  v_res = {16'h0000, v_half};
      default: v_res = 32'h00000000;
    endcase
    return v_res;
  endfunction

`ifdef JZJPCC_LOAD_MISALIGN_CHECK_EN
  // Halfwords need an even offset, words need offset 0; bytes never fault.
  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic v_mis;
    case (f3)
      3'b001:  v_mis = off[0];
      3'b101:  v_mis = off[0];
      3'b010:  v_mis = (off != 2'd0);
      default: v_mis = 1'b0;
    endcase
    return v_mis;
  endfunction

  assign w_misaligned = is_misaligned(funct3_execute, byteOffset_execute);
`else
  assign w_misaligned = 1'b0;
`endif

  // Load FSM: capture in IDLE, wait for data or watchdog in WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= 8'd0;
      r_funct3     <= 3'b000;
      r_offset     <= 2'd0;
      r_rd         <= 5'd0;
      r_result     <= 32'h00000000;
      r_valid      <= 1'b0;
      r_rd_wb      <= 5'd0;
      r_timeout    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      // Pulses default low and are raised only for the cycle they report.
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Responses arriving here are stale and simply dropped.
          if (loadStart_execute) begin
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_funct3 <= funct3_execute;
              r_offset <= byteOffset_execute;
              r_rd     <= rdAddress_execute;
              r_count  <= 8'd0;
              r_state  <= ST_WAIT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Data takes priority over a watchdog expiring in the same cycle.
          if (memReadValid) begin
            r_result <= extract_load(r_funct3, r_offset, memReadData);
            r_rd_wb  <= r_rd;
            r_valid  <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (r_count == TIMEOUT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_count <= r_count + 8'd1;
            r_state <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall the pipeline for as long as a load is outstanding.
  assign loadBusy                  = (r_state == ST_WAIT);
  assign loadResult_writeback      = r_result;
  assign loadResultValid_writeback = r_valid;
  assign rdAddress_writeback       = r_rd_wb;
  assign loadTimeout               = r_timeout;
  assign loadMisaligned            = r_misaligned;

endmodule

// File: tb/tb_jzjpcc_mem_load_returner.sv
// Testbench for jzjpcc_mem_load_returner. Two instances share stimulus:
// u_dut uses the default watchdog, u_dut_to uses TIMEOUT_CYCLES=4.
module tb_jzjpcc_mem_load_returner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        loadStart_execute = 1'b0;
  logic [2:0]  funct3_execute = 3'b000;
  logic [1:0]  byteOffset_execute = 2'd0;
  logic [4:0]  rdAddress_execute = 5'd0;
  logic        memReadValid = 1'b0;
  logic [31:0] memReadData = 32'h00000000;

  logic [31:0] d_result, t_result;
  logic        d_valid, t_valid;
  logic [4:0]  d_rd, t_rd;
  logic        d_busy, t_busy;
  logic        d_to, t_to;
  logic        d_mis, t_mis;

  int checks = 0;
  int failures = 0;

  jzjpcc_mem_load_returner u_dut (
    .clock(clock), .reset(reset),
    .loadStart_execute(loadStart_execute), .funct3_execute(funct3_execute),
    .byteOffset_execute(byteOffset_execute), .rdAddress_execute(rdAddress_execute),
    .memReadValid(memReadValid), .memReadData(memReadData),
    .loadResult_writeback(d_result), .loadResultValid_writeback(d_valid),
    .rdAddress_writeback(d_rd), .loadBusy(d_busy),
    .loadTimeout(d_to), .loadMisaligned(d_mis)
  );

  jzjpcc_mem_load_returner #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clock(clock), .reset(reset),
    .loadStart_execute(loadStart_execute), .funct3_execute(funct3_execute),
    .byteOffset_execute(byteOffset_execute), .rdAddress_execute(rdAddress_execute),
    .memReadValid(memReadValid), .memReadData(memReadData),
    .loadResult_writeback(t_result), .loadResultValid_writeback(t_valid),
    .rdAddress_writeback(t_rd), .loadBusy(t_busy),
    .loadTimeout(t_to), .loadMisaligned(t_mis)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle past the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (d_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", d_result); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", d_valid); end
    checks++; if (d_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", d_rd); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", d_busy); end
    checks++; if (d_to !== 1'b0 || t_to !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b/%b exp=0/0", d_to, t_to); end
    checks++; if (d_mis !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", d_mis); end
  endtask

  // Issue one load, answer it after 'delay' WAIT cycles, check result and hold.
  task automatic test_load(input string nm, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] data, input int delay,
                           input logic [31:0] exp);
    funct3_execute = f3;
    byteOffset_execute = off;
    rdAddress_execute = rd;
    loadStart_execute = 1'b1;
    memReadData = 32'hDEADBEEF;
    tick();
    // Scramble the execute inputs so only latched values can produce the result.
    loadStart_execute = 1'b0;
    funct3_execute = 3'b111;
    byteOffset_execute = ~off;
    rdAddress_execute = ~rd;
    for (int k = 1; k <= delay; k++) begin
      checks++;
      if (d_busy !== 1'b1 || d_valid !== 1'b0 || d_mis !== 1'b0) begin
        failures++;
        $display("FAIL %s_wait cycle=%0d busy=%b valid=%b mis=%b exp busy=1 valid=0 mis=0", nm, k, d_busy, d_valid, d_mis);
      end
      if (k == delay) begin
        memReadValid = 1'b1;
        memReadData = data;
      end
      tick();
    end
    memReadValid = 1'b0;
    memReadData = 32'hDEADBEEF;
    checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", nm, d_valid); end
    checks++; if (d_result !== exp) begin failures++; $display("FAIL %s_result got=%h exp=%h", nm, d_result, exp); end
    checks++; if (d_rd !== rd) begin failures++; $display("FAIL %s_rd got=%0d exp=%0d", nm, d_rd, rd); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL %s_busy_done got=%b exp=0", nm, d_busy); end
    tick();
    checks++;
    if (d_valid !== 1'b0 || d_result !== exp) begin
      failures++;
      $display("FAIL %s_hold valid=%b result=%h exp valid=0 result=%h", nm, d_valid, d_result, exp);
    end
  endtask

  task automatic test_back_to_back();
    funct3_execute = 3'b100; byteOffset_execute = 2'd1; rdAddress_execute = 5'd4;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    memReadValid = 1'b1; memReadData = 32'h0000AB00;
    tick();
    memReadValid = 1'b0;
    checks++; if (d_valid !== 1'b1 || d_result !== 32'h000000AB) begin failures++; $display("FAIL b2b_first valid=%b result=%h exp valid=1 result=000000ab", d_valid, d_result); end
    // Second load issued on the very cycle the first result is presented.
    funct3_execute = 3'b001; byteOffset_execute = 2'd0; rdAddress_execute = 5'd7;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    checks++; if (d_busy !== 1'b1 || d_valid !== 1'b0) begin failures++; $display("FAIL b2b_second_wait busy=%b valid=%b exp busy=1 valid=0", d_busy, d_valid); end
    checks++; if (d_result !== 32'h000000AB || d_rd !== 5'd4) begin failures++; $display("FAIL b2b_hold result=%h rd=%0d exp result=000000ab rd=4", d_result, d_rd); end
    memReadValid = 1'b1; memReadData = 32'h1234F00F;
    tick();
    memReadValid = 1'b0;
    checks++; if (d_valid !== 1'b1 || d_result !== 32'hFFFFF00F || d_rd !== 5'd7) begin failures++; $display("FAIL b2b_second valid=%b result=%h rd=%0d exp valid=1 result=fffff00f rd=7", d_valid, d_result, d_rd); end
    tick();
  endtask

  task automatic test_timeout();
    funct3_execute = 3'b010; byteOffset_execute = 2'd0; rdAddress_execute = 5'd12;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (t_busy !== 1'b1 || t_to !== 1'b0) begin failures++; $display("FAIL timeout_wait cycle=%0d busy=%b timeout=%b exp busy=1 timeout=0", k, t_busy, t_to); end
      tick();
    end
    checks++; if (t_to !== 1'b1) begin failures++; $display("FAIL timeout_pulse got=%b exp=1", t_to); end
    checks++; if (t_valid !== 1'b0 || t_busy !== 1'b0) begin failures++; $display("FAIL timeout_state valid=%b busy=%b exp valid=0 busy=0", t_valid, t_busy); end
    checks++; if (d_busy !== 1'b1 || d_to !== 1'b0) begin failures++; $display("FAIL timeout_default_wait busy=%b timeout=%b exp busy=1 timeout=0", d_busy, d_to); end
    tick();
    checks++; if (t_to !== 1'b0) begin failures++; $display("FAIL timeout_one_cycle got=%b exp=0", t_to); end
    // Late response: ignored by the aborted instance, accepted by the patient one.
    memReadValid = 1'b1; memReadData = 32'hCAFEF00D;
    tick();
    memReadValid = 1'b0;
    checks++; if (t_valid !== 1'b0) begin failures++; $display("FAIL timeout_late_ignored valid=%b exp=0", t_valid); end
    checks++; if (d_valid !== 1'b1 || d_result !== 32'hCAFEF00D || d_rd !== 5'd12) begin failures++; $display("FAIL timeout_default_result valid=%b result=%h rd=%0d exp valid=1 result=cafef00d rd=12", d_valid, d_result, d_rd); end
    tick();
    checks++; if (t_valid !== 1'b0 || t_to !== 1'b0) begin failures++; $display("FAIL timeout_quiet valid=%b timeout=%b exp 0/0", t_valid, t_to); end
  endtask

  task automatic test_data_beats_timeout();
    funct3_execute = 3'b000; byteOffset_execute = 2'd0; rdAddress_execute = 5'd2;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (t_busy !== 1'b1) begin failures++; $display("FAIL coincide_wait cycle=%0d busy=%b exp=1", k, t_busy); end
      if (k == 4) begin
        memReadValid = 1'b1; memReadData = 32'h00000081;
      end
      tick();
    end
    memReadValid = 1'b0;
    checks++; if (t_valid !== 1'b1 || t_to !== 1'b0) begin failures++; $display("FAIL coincide_pulses valid=%b timeout=%b exp valid=1 timeout=0", t_valid, t_to); end
    checks++; if (t_result !== 32'hFFFFFF81 || t_rd !== 5'd2) begin failures++; $display("FAIL coincide_result result=%h rd=%0d exp result=ffffff81 rd=2", t_result, t_rd); end
    tick();
    checks++; if (t_to !== 1'b0 || t_busy !== 1'b0) begin failures++; $display("FAIL coincide_after timeout=%b busy=%b exp 0/0", t_to, t_busy); end
  endtask

  task automatic test_reset_in_wait();
    funct3_execute = 3'b010; byteOffset_execute = 2'd0; rdAddress_execute = 5'd20;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    memReadValid = 1'b1; memReadData = 32'hFFFFFFFF;
    tick();
    memReadValid = 1'b0;
    checks++; if (d_valid !== 1'b0 || t_valid !== 1'b0) begin failures++; $display("FAIL rstwait_valid got=%b/%b exp=0/0", d_valid, t_valid); end
    checks++; if (d_result !== 32'h0 || d_rd !== 5'd0) begin failures++; $display("FAIL rstwait_outputs result=%h rd=%0d exp result=00000000 rd=0", d_result, d_rd); end
    checks++; if (d_busy !== 1'b0 || d_to !== 1'b0) begin failures++; $display("FAIL rstwait_busy busy=%b timeout=%b exp 0/0", d_busy, d_to); end
    tick();
    test_load("after_reset", 3'b001, 2'd0, 5'd21, 32'h00008000, 2, 32'hFFFF8000);
  endtask

  task automatic test_misalign();
`ifdef JZJPCC_LOAD_MISALIGN_CHECK_EN
    funct3_execute = 3'b010; byteOffset_execute = 2'd1; rdAddress_execute = 5'd5;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    checks++; if (d_mis !== 1'b1) begin failures++; $display("FAIL mis_lw_pulse got=%b exp=1", d_mis); end
    checks++; if (d_busy !== 1'b0 || d_valid !== 1'b0) begin failures++; $display("FAIL mis_lw_state busy=%b valid=%b exp 0/0", d_busy, d_valid); end
    memReadValid = 1'b1; memReadData = 32'h89ABCDEF;
    tick();
    memReadValid = 1'b0;
    checks++; if (d_mis !== 1'b0 || d_valid !== 1'b0) begin failures++; $display("FAIL mis_lw_after mis=%b valid=%b exp 0/0", d_mis, d_valid); end
    funct3_execute = 3'b101; byteOffset_execute = 2'd3;
    loadStart_execute = 1'b1;
    tick();
    loadStart_execute = 1'b0;
    checks++; if (d_mis !== 1'b1 || d_busy !== 1'b0) begin failures++; $display("FAIL mis_lhu_pulse mis=%b busy=%b exp mis=1 busy=0", d_mis, d_busy); end
    tick();
    test_load("lhu_off2_aligned", 3'b101, 2'd2, 5'd6, 32'hBEEF0000, 1, 32'h0000BEEF);
`else
    test_load("lw_off1", 3'b010, 2'd1, 5'd5, 32'h89ABCDEF, 1, 32'h89ABCDEF);
    test_load("lhu_off1", 3'b101, 2'd1, 5'd6, 32'h1234ABCD, 1, 32'h0000ABCD);
    test_load("lh_off3", 3'b001, 2'd3, 5'd8, 32'h9876_0000, 1, 32'hFFFF9876);
`endif
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load("lb_off2", 3'b000, 2'd2, 5'd3, 32'h12F45678, 1, 32'hFFFFFFF4);
    test_load("lbu_off2", 3'b100, 2'd2, 5'd3, 32'h12F45678, 1, 32'h000000F4);
    test_load("lh_off2", 3'b001, 2'd2, 5'd10, 32'h80017FFF, 1, 32'hFFFF8001);
    test_load("lhu_off0", 3'b101, 2'd0, 5'd11, 32'h80017FFF, 1, 32'h00007FFF);
    test_load("lw_delay5", 3'b010, 2'd0, 5'd9, 32'hA5C30F96, 5, 32'hA5C30F96);
    test_load("lb_off3", 3'b000, 2'd3, 5'd31, 32'h80000000, 3, 32'hFFFFFF80);
    test_load("lb_off0_pos", 3'b000, 2'd0, 5'd1, 32'hFFFFFF7F, 1, 32'h0000007F);
    test_load("f3_011", 3'b011, 2'd0, 5'd13, 32'hFFFFFFFF, 1, 32'h00000000);
    test_load("f3_110", 3'b110, 2'd0, 5'd14, 32'hFFFFFFFF, 2, 32'h00000000);
    test_back_to_back();
    test_timeout();
    test_data_beats_timeout();
    test_reset_in_wait();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
